// File: rtl/tx_pkg.sv
// Shared constants and helpers for the UART-style TX path.
// The serializer and its bit counter are both sized from these.
package tx_pkg;

  localparam int DATA_WIDTH = 8;

  // This is the width of a counter that holds 0 .. w-1. It is legal for w >= 2.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

  localparam int CNT_W = cnt_w(DATA_WIDTH);

endpackage

// File: rtl/data_serializer_if.sv
// Upstream/TX-FSM signal bundle for data_serializer, with debug taps of its state.
// Handshake: a word is captured on any CLK edge where Data_Valid=1 and Busy=0; the serializer
// never back-pressures, so upstream holds Busy=1 while a frame must not be disturbed.
interface data_serializer_if import tx_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH
) ();

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] DATA;
  logic             Enable;
  logic             Busy;
  logic             Data_Valid;
  logic             ser_out;
  logic             ser_done;
  logic [WIDTH-1:0] dbg_data;
  logic [CW-1:0]    dbg_cnt;

  modport master (
    output DATA, Enable, Busy, Data_Valid,
    input  ser_out, ser_done, dbg_data, dbg_cnt
  );

  modport slave (
    input  DATA, Enable, Busy, Data_Valid,
    output ser_out, ser_done, dbg_data, dbg_cnt
  );

endinterface

// File: rtl/ser_bit_counter.sv
// Counts bits shifted in the current frame and wraps to 0 after bit WIDTH-1.
// clr takes priority over inc.
module ser_bit_counter import tx_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH,
  localparam int CW   = cnt_w(WIDTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q, count_d;

  assign last = (count_q == CW'(WIDTH - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/data_serializer.sv
// Parallel-to-serial converter: captures a word when it is valid and the link is idle,
// then shifts it out LSB-first, one bit per enabled clock, flagging the last bit.
module data_serializer import tx_pkg::*; #(
  parameter int WIDTH = DATA_WIDTH
) (
  input logic           CLK,
  input logic           RST,
  data_serializer_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic             load;
  logic             shift;
  logic [CW-1:0]    bit_cnt;
  logic             bit_last;

  // A load restarts the frame even mid-shift, and it overrides Enable on that edge.
  assign load  = bus.Data_Valid & ~bus.Busy;
  assign shift = bus.Enable & ~load;

  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (load),
    .inc   (shift),
    .count (bit_cnt),
    .last  (bit_last)
  );

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = bus.DATA;
    end else if (shift) begin
      data_d = data_q >> 1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.ser_out  = data_q[0];
  assign bus.ser_done = bus.Enable & bit_last;
  assign bus.dbg_data = data_q;
  assign bus.dbg_cnt  = bit_cnt;

endmodule

// File: tb/tb_data_serializer.sv
// Directed bench for data_serializer (WIDTH=8): a bit-queue model is checked every cycle,
// and hand-computed literals pin the model at each scenario.
module tb_data_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;

  // Clock/reset block
  always #5 clk = ~clk;

  data_serializer_if #(.WIDTH(W)) bus ();

  data_serializer #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Model: the bits still to be sent, front = bit on the wire, plus bits already sent this frame.
  logic     bit_q[$];
  int       sent = 0;

  always @(posedge clk) begin
    if (rst) begin
      bit_q.delete();
      sent = 0;
    end else if (bus.Data_Valid && !bus.Busy) begin
      bit_q.delete();
      for (int i = 0; i < W; i++) bit_q.push_back(bus.DATA[i]);
      sent = 0;
    end else if (bus.Enable) begin
      if (bit_q.size() > 0) void'(bit_q.pop_front());
      sent = (sent + 1) % W;
    end
  end

  function automatic logic [W-1:0] model_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < bit_q.size(); i++) w[i] = bit_q[i];
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare, every cycle once checking is armed.
  always @(negedge clk) begin
    if (check_en) begin
      chk("sb_ser_out",  32'(bus.ser_out),  32'(bit_q.size() > 0 ? bit_q[0] : 1'b0));
      chk("sb_ser_done", 32'(bus.ser_done), 32'(bus.Enable && sent == W - 1));
      chk("sb_data_reg", 32'(bus.dbg_data), 32'(model_word()));
      chk("sb_bit_cnt",  32'(bus.dbg_cnt),  32'(sent));
    end
  end

  // Driver tasks: inputs change 1 time unit after the falling edge.
  task automatic drv(input logic r, input logic v, input logic b, input logic e,
                     input logic [W-1:0] d);
    #1;
    rst            = r;
    bus.Data_Valid = v;
    bus.Busy       = b;
    bus.Enable     = e;
    bus.DATA       = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [W-1:0] pat;
  logic [W-1:0] seq07;

  initial begin
    rst = 1'b1;
    bus.Data_Valid = 1'b0;
    bus.Busy       = 1'b0;
    bus.Enable     = 1'b0;
    bus.DATA       = '0;

    // Reset
    step();
    chk("rst_ser_out",  32'(bus.ser_out),  32'd0);
    chk("rst_ser_done", 32'(bus.ser_done), 32'd0);
    chk("rst_data_reg", 32'(bus.dbg_data), 32'd0);
    chk("rst_bit_cnt",  32'(bus.dbg_cnt),  32'd0);
    check_en = 1'b1;

    // Load 05
    drv(0, 1, 0, 0, 8'h05); step();
    chk("load_data_reg", 32'(bus.dbg_data), 32'h05);
    chk("load_ser_out",  32'(bus.ser_out),  32'd1);

    // Blocked load
    drv(0, 1, 1, 0, 8'h03); step();
    chk("blocked_data_reg", 32'(bus.dbg_data), 32'h05);

    // Serialize 07 with DATA scrambled every cycle
    seq07 = 8'b0000_0111;
    drv(0, 1, 0, 0, 8'h07); step();
    for (int i = 0; i < W; i++) begin
      drv(0, 0, 1, 1, W'($urandom_range(0, 255)));
      #1;
      chk("ser07_bit",  32'(bus.ser_out),  32'(seq07[i]));
      chk("ser07_done", 32'(bus.ser_done), 32'(i == W - 1));
      step();
    end
    drv(0, 0, 1, 0, 8'h00);
    #1;
    chk("ser07_empty", 32'(bus.dbg_data), 32'd0);
    chk("ser07_out0",  32'(bus.ser_out),  32'd0);
    chk("ser07_cnt0",  32'(bus.dbg_cnt),  32'd0);
    step();

    // Pause after bit 2
    pat = 8'hB5;
    drv(0, 1, 0, 0, pat); step();
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 1, 1, W'($urandom_range(0, 255))); step();
    end
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 1, 0, W'($urandom_range(0, 255))); step();
      chk("pause_ser_out",  32'(bus.ser_out),  32'd1);
      chk("pause_bit_cnt",  32'(bus.dbg_cnt),  32'd2);
      chk("pause_ser_done", 32'(bus.ser_done), 32'd0);
    end
    for (int i = 2; i < W; i++) begin
      drv(0, 0, 1, 1, W'($urandom_range(0, 255)));
      #1;
      chk("resume_bit",  32'(bus.ser_out),  32'(pat[i]));
      chk("resume_done", 32'(bus.ser_done), 32'(i == W - 1));
      step();
    end

    // Reload mid-frame: load wins over Enable
    drv(0, 1, 0, 0, 8'hAA); step();
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 1, 8'h00); step();
    end
    drv(0, 1, 0, 1, 8'h3C); step();
    chk("reload_data_reg", 32'(bus.dbg_data), 32'h3C);
    chk("reload_bit_cnt",  32'(bus.dbg_cnt),  32'd0);

    // Reset at bit 4
    drv(0, 1, 0, 0, 8'hFF); step();
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, 1, 8'h00); step();
    end
    chk("mid_bit_cnt", 32'(bus.dbg_cnt), 32'd4);
    drv(1, 0, 1, 1, 8'h00);
    #1;
    chk("midrst_no_done", 32'(bus.ser_done), 32'd0);
    step();
    chk("midrst_data_reg", 32'(bus.dbg_data), 32'd0);
    chk("midrst_bit_cnt",  32'(bus.dbg_cnt),  32'd0);
    drv(0, 0, 0, 0, 8'h00); step(); step();

    // Enable with no prior load
    for (int i = 0; i < W; i++) begin
      drv(0, 0, 0, 1, 8'h00);
      #1;
      chk("noload_bit",  32'(bus.ser_out),  32'd0);
      chk("noload_done", 32'(bus.ser_done), 32'(i == W - 1));
      step();
    end
    drv(0, 0, 0, 0, 8'h00); step(); step();
    check_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
